// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The master drives operands and the start/annul handshake; the slave returns {HI, LO} and status.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div.sv
// 32-cycle restoring divider (DIV/DIVU), result {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN short-circuits a zero divisor through BYZERO.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | zero divisor seen, result forced to 0 (fast path only)
// ON     | one shift-subtract step per cycle, 32 cycles
// END    | result valid, held until start_i falls
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_sign_a;
    logic        r_sign_b;

    logic        w_accept;
    logic        w_last;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_trial;
    logic [31:0] w_quo_step;
    logic [31:0] w_rem_step;
`ifdef DIV_ZERO_FAST_EN
    logic        w_zero_div;
    assign w_zero_div = (bus.opdata2_i == 32'd0);
`endif

    assign w_accept = bus.start_i & ~bus.annul_i;
    assign w_last   = (r_cnt == 6'd31);
    assign w_neg_a  = bus.signed_div_i & bus.opdata1_i[31];
    assign w_neg_b  = bus.signed_div_i & bus.opdata2_i[31];
    assign w_abs_a  = w_neg_a ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    assign w_abs_b  = w_neg_b ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;

    // Partial remainder stays below the divisor, so bit 32 of the trial is a clean borrow flag.
    assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_divisor};

    always_comb begin
        if (w_trial[32]) begin
            w_rem_step = {r_rem[30:0], r_quo[31]};
            w_quo_step = {r_quo[30:0], 1'b0};
        end else begin
            w_rem_step = w_trial[31:0];
            w_quo_step = {r_quo[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FREE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.busy_o   = 1'b1;
        bus.ready_o  = 1'b0;
        bus.result_o = 64'd0;
        case (r_state)
            FREE: begin
                bus.busy_o = 1'b0;
                if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
                    w_next = w_zero_div ? BYZERO : ON;
`else
                    w_next = ON;
`endif
                end
            end
            BYZERO: begin
                w_next = bus.annul_i ? FREE : END;
            end
            ON: begin
                if (bus.annul_i) begin
                    w_next = FREE;
                end else if (w_last) begin
                    w_next = END;
                end
            end
            END: begin
                bus.ready_o  = 1'b1;
                bus.result_o = {r_rem, r_quo};
                if (!bus.start_i) begin
                    w_next = FREE;
                end
            end
            default: w_next = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 6'd0;
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
        end else begin
            case (r_state)
                FREE: begin
                    if (w_accept) begin
                        r_cnt     <= 6'd0;
                        r_quo     <= w_abs_a;
                        r_rem     <= 32'd0;
                        r_divisor <= w_abs_b;
                        r_sign_a  <= w_neg_a;
                        r_sign_b  <= w_neg_b;
                    end
                end
                BYZERO: begin
                    r_quo <= 32'd0;
                    r_rem <= 32'd0;
                end
                ON: begin
                    if (!bus.annul_i) begin
                        r_cnt <= r_cnt + 6'd1;
                        // Sign correction folds into the final step so END holds a finished result.
                        if (w_last) begin
                            r_quo <= (r_sign_a ^ r_sign_b) ? (32'd0 - w_quo_step) : w_quo_step;
                            r_rem <= r_sign_a ? (32'd0 - w_rem_step) : w_rem_step;
                        end else begin
                            r_quo <= w_quo_step;
                            r_rem <= w_rem_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized operands against an arithmetic model.
module tb_div;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    div_if u_if ();
    div u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, qm, rm, t;
        logic   na, nb;
        logic [31:0] q, r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? -longint'($signed(a)) : longint'(a);
        mb = nb ? -longint'($signed(b)) : longint'(b);
        if (mb == 0) begin
            qm = 64'hFFFF_FFFF;
            rm = ma;
        end else begin
            qm = ma / mb;
            rm = ma % mb;
        end
        t = (na ^ nb) ? -qm : qm;
        q = t[31:0];
        t = na ? -rm : rm;
        r = t[31:0];
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 64'd0;
`endif
        return {r, q};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 2;
`endif
        return 33;
    endfunction

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        int lat;
        logic [63:0] exp_res;
        exp_res = ref_div(sgn, a, b);
        lat = -1;
        @(negedge clk);
        u_if.signed_div_i = sgn;
        u_if.opdata1_i    = a;
        u_if.opdata2_i    = b;
        u_if.start_i      = 1'b1;
        u_if.annul_i      = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) begin
                u_if.opdata1_i = $urandom;
                u_if.opdata2_i = $urandom;
            end
            if (u_if.ready_o) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(ref_lat(b)));
        chk({tag, " result"}, u_if.result_o, exp_res);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, " hold"}, {u_if.ready_o, u_if.result_o}, {1'b1, exp_res});
        end
        u_if.start_i = 1'b0;
        @(negedge clk);
        chk({tag, " free"}, {u_if.busy_o, u_if.ready_o, u_if.result_o}, 66'd0);
    endtask

    initial begin
        logic        seen;
        logic        sgn;
        logic [31:0] a, b;
        rst               = 1'b0;
        u_if.signed_div_i = 1'b0;
        u_if.opdata1_i    = 32'd0;
        u_if.opdata2_i    = 32'd0;
        u_if.start_i      = 1'b0;
        u_if.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {u_if.busy_o, u_if.ready_o, u_if.result_o}, 66'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op("u100/7", 1'b0, 32'd100, 32'd7, 3);
        do_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("u5/0", 1'b0, 32'd5, 32'd0, 1);
        do_op("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("smin/-1 model", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
        chk("s-7/2 model", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // annul at N+10: FREE from N+11, ready never seen
        @(negedge clk);
        u_if.signed_div_i = 1'b0;
        u_if.opdata1_i    = 32'd1000;
        u_if.opdata2_i    = 32'd3;
        u_if.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        chk("annul busy N+10", 64'(u_if.busy_o), 64'd1);
        u_if.annul_i = 1'b1;
        u_if.start_i = 1'b0;
        @(negedge clk);
        u_if.annul_i = 1'b0;
        chk("annul N+11", {u_if.busy_o, u_if.ready_o}, 2'b00);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | u_if.ready_o | u_if.busy_o;
        end
        chk("annul quiet", 64'(seen), 64'd0);

        // start and annul together in FREE
        u_if.start_i = 1'b1;
        u_if.annul_i = 1'b1;
        @(negedge clk);
        chk("start+annul", {u_if.busy_o, u_if.ready_o}, 2'b00);
        u_if.start_i = 1'b0;
        u_if.annul_i = 1'b0;

        // reset mid-operation at N+15
        @(negedge clk);
        u_if.opdata1_i = 32'd50;
        u_if.opdata2_i = 32'd5;
        u_if.start_i   = 1'b1;
        repeat (15) @(negedge clk);
        chk("pre-reset busy", 64'(u_if.busy_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("async reset", {u_if.busy_o, u_if.ready_o, u_if.result_o}, 66'd0);
        u_if.start_i = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | u_if.ready_o;
        end
        chk("no ready after reset", 64'(seen), 64'd0);
        do_op("u9/3", 1'b0, 32'd9, 32'd3, 0);

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom;
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom_range(1, 1000);
            endcase
            do_op("random", sgn, a, b, i % 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
